fluxo_dados_contador_param: RTL



---
 rtl/fluxo_dados_contador_param.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fluxo_dados_contador_param.sv
// Parametrised counter datapath: loadable modulo-M up/down counter, magnitude
// comparator against the switches, saturating match counter and hex display.

module hexa7seg (
    input  logic [3:0] hexa,
    output logic [6:0] display
);
    // Active-low segments, bit order gfedcba.
    always_comb begin
        display = 7'b1111111;
        case (hexa)
            4'h0: display = 7'b1000000;
            4'h1: display = 7'b1111001;
            4'h2: display = 7'b0100100;
            4'h3: display = 7'b0110000;
            4'h4: display = 7'b0011001;
            4'h5: display = 7'b0010010;
            4'h6: display = 7'b0000010;
            4'h7: display = 7'b1111000;
            4'h8: display = 7'b0000000;
            4'h9: display = 7'b0010000;
            4'hA: display = 7'b0001000;
            4'hB: display = 7'b0000011;
            4'hC: display = 7'b1000110;
            4'hD: display = 7'b0100001;
            4'hE: display = 7'b0000110;
            4'hF: display = 7'b0001110;
            default: display = 7'b1111111;
        endcase
    end
endmodule

module fluxo_dados_contador_param #(
    parameter int N      = 4,
    parameter int MODULO = 16
) (
    input  logic                         clock,
    input  logic                         zera,
    input  logic                         carrega,
    input  logic                         conta,
    input  logic                         direcao,
    input  logic                         satura,
    input  logic [N-1:0]                 chaves,
    output logic                         menor,
    output logic                         maior,
    output logic                         igual,
    output logic                         fim,
    output logic [N-1:0]                 db_acertos,
    output logic [7*((N+3)/4)-1:0]       db_contagem
);
    localparam int DIGITS = (N + 3) / 4;
    localparam logic [N-1:0] MAX_COUNT   = N'(MODULO - 1);
    localparam logic [N-1:0] ACERTOS_MAX = {N{1'b1}};

    if (N < 2 || N > 16 || MODULO < 2 || MODULO > (1 << N)) begin : g_bad_param
        $error("fluxo_dados_contador_param: illegal N/MODULO combination");
    end

    logic [N-1:0] count_q, count_d;
    logic [N-1:0] acertos_q, acertos_d;
    logic         igual_ant_q, igual_ant_d;

    always_comb begin
        menor = (count_q < chaves);
        maior = (count_q > chaves);
        igual = (count_q == chaves);
        fim   = direcao ? (count_q == MAX_COUNT) : (count_q == '0);
    end

    always_comb begin
        count_d     = count_q;
        acertos_d   = acertos_q;
        igual_ant_d = igual;

        if (zera) begin
            count_d     = '0;
            acertos_d   = '0;
            // Starting "already matched" keeps a match present at reset release uncounted.
            igual_ant_d = 1'b1;
        end else begin
            if (igual && !igual_ant_q && acertos_q != ACERTOS_MAX) begin
                acertos_d = acertos_q + N'(1);
            end

            if (carrega) begin
                count_d = (chaves > MAX_COUNT) ? MAX_COUNT : chaves;
            end else if (conta) begin
                if (direcao) begin
                    if (count_q != MAX_COUNT) begin
                        count_d = count_q + N'(1);
                    end else if (!satura) begin
                        count_d = '0;
                    end
                end else begin
                    if (count_q != '0) begin
                        count_d = count_q - N'(1);
                    end else if (!satura) begin
                        count_d = MAX_COUNT;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (zera) begin
            count_q     <= '0;
            acertos_q   <= '0;
            igual_ant_q <= 1'b1;
        end else begin
            count_q     <= count_d;
            acertos_q   <= acertos_d;
            igual_ant_q <= igual_ant_d;
        end
    end

    assign db_acertos = acertos_q;

    logic [4*DIGITS-1:0] count_ext;
    assign count_ext = (4*DIGITS)'(count_q);

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        hexa7seg u_hex (
            .hexa    (count_ext[4*k +: 4]),
            .display (db_contagem[7*k +: 7])
        );
    end
endmodule
